// File: rtl/sdram_init_cfg.sv
// SDRAM power-up initialisation sequencer.
// Runs the power-up wait, precharge-all, auto-refresh burst and mode register load, then holds in DONE.
module sdram_init_cfg #(
  parameter int unsigned CLK_MHZ     = 100,
  parameter int unsigned WAIT_US     = 200,
  parameter int unsigned TRP_CYC     = 2,
  parameter int unsigned TRFC_CYC    = 7,
  parameter int unsigned TMRD_CYC    = 3,
  parameter int unsigned REF_NUM     = 8,
  parameter int unsigned ADDR_W      = 13,
  parameter int unsigned BA_W        = 2,
  parameter int unsigned CAS_LAT     = 3,
  parameter logic [2:0]  BURST_LEN   = 3'b111,
  parameter bit          BURST_TYPE  = 1'b0,
  parameter bit          WRITE_BURST = 1'b0
) (
  input  logic              i_sysclk,
  input  logic              i_sysrst,
  input  logic              i_reinit_req,
  output logic [3:0]        o_init_cmd,
  output logic [BA_W-1:0]   o_init_ba,
  output logic [ADDR_W-1:0] o_init_addr,
  output logic              o_init_done,
  output logic              o_init_busy
);

  localparam int unsigned WAIT_CYCLES = CLK_MHZ * WAIT_US;
  localparam int unsigned WAIT_W      = $clog2(WAIT_CYCLES + 1);
  localparam int unsigned GAP_W       = $clog2(16);
  localparam int unsigned REF_W       = $clog2(REF_NUM + 1);

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_LMR  = 4'b0000;

  localparam logic [ADDR_W-1:0] MODE_WORD =
    ADDR_W'({1'(WRITE_BURST), 2'b00, 3'(CAS_LAT), 1'(BURST_TYPE), BURST_LEN});

  localparam bit PARAM_OK =
    (TRP_CYC  != 0) && (TRP_CYC  <= 15) &&
    (TRFC_CYC != 0) && (TRFC_CYC <= 15) &&
    (TMRD_CYC != 0) && (TMRD_CYC <= 15) &&
    (REF_NUM  != 0) && (REF_NUM  <= 16) &&
    (ADDR_W >= 10) && (BA_W != 0) && (WAIT_CYCLES != 0) &&
    ((CAS_LAT == 2) || (CAS_LAT == 3));

  if (!PARAM_OK) begin : g_param_err
    $error("sdram_init_cfg: parameter value outside legal range");
  end

  // Gray-coded so every transition along the sequence flips a single bit
  typedef enum logic [2:0] {
    S_IDLE_WAIT = 3'b000,
    S_PRE       = 3'b001,
    S_TRP       = 3'b011,
    S_AREF      = 3'b010,
    S_TRFC      = 3'b110,
    S_LMR       = 3'b111,
    S_TMRD      = 3'b101,
    S_DONE      = 3'b100
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [WAIT_W-1:0]   r_wait_cnt, w_wait_nxt;
  logic [GAP_W-1:0]    r_gap_cnt, w_gap_nxt;
  logic [REF_W-1:0]    r_ref_cnt, w_ref_nxt;
  logic [3:0]          r_cmd, w_cmd;
  logic [BA_W-1:0]     r_ba, w_ba;
  logic [ADDR_W-1:0]   r_addr, w_addr;
  logic                r_done, w_done;
  logic                r_busy, w_busy;

  // Outputs are decoded from the next state so they line up with r_state
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_gap_nxt   = '0;
    w_ref_nxt   = r_ref_cnt;
    case (r_state)
      S_IDLE_WAIT: begin
        if (r_wait_cnt == WAIT_W'(WAIT_CYCLES)) w_state_nxt = S_PRE;
        else                                    w_wait_nxt  = r_wait_cnt + WAIT_W'(1);
      end
      S_PRE: begin
        w_state_nxt = S_TRP;
        w_ref_nxt   = '0;
      end
      S_TRP: begin
        if (r_gap_cnt == GAP_W'(TRP_CYC - 1)) w_state_nxt = S_AREF;
        else                                  w_gap_nxt   = r_gap_cnt + GAP_W'(1);
      end
      S_AREF: begin
        w_state_nxt = S_TRFC;
        w_ref_nxt   = r_ref_cnt + REF_W'(1);
      end
      S_TRFC: begin
        if (r_gap_cnt == GAP_W'(TRFC_CYC - 1))
          w_state_nxt = (r_ref_cnt == REF_W'(REF_NUM)) ? S_LMR : S_AREF;
        else
          w_gap_nxt = r_gap_cnt + GAP_W'(1);
      end
      S_LMR: w_state_nxt = S_TMRD;
      S_TMRD: begin
        if (r_gap_cnt == GAP_W'(TMRD_CYC - 1)) w_state_nxt = S_DONE;
        else                                   w_gap_nxt   = r_gap_cnt + GAP_W'(1);
      end
      S_DONE: if (i_reinit_req) w_state_nxt = S_PRE;
      default: w_state_nxt = S_IDLE_WAIT;
    endcase

    w_cmd  = CMD_NOP;
    w_ba   = '1;
    w_addr = '1;
    case (w_state_nxt)
      S_PRE:  w_cmd = CMD_PRE;
      S_AREF: w_cmd = CMD_AREF;
      S_LMR: begin
        w_cmd  = CMD_LMR;
        w_ba   = '0;
        w_addr = MODE_WORD;
      end
      default: w_cmd = CMD_NOP;
    endcase
    w_done = (w_state_nxt == S_DONE);
    w_busy = !w_done;
  end

  always_ff @(posedge i_sysclk) begin
    if (i_sysrst) begin
      r_state    <= S_IDLE_WAIT;
      r_wait_cnt <= '0;
      r_gap_cnt  <= '0;
      r_ref_cnt  <= '0;
      r_cmd      <= CMD_NOP;
      r_ba       <= '1;
      r_addr     <= '1;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_gap_cnt  <= w_gap_nxt;
      r_ref_cnt  <= w_ref_nxt;
      r_cmd      <= w_cmd;
      r_ba       <= w_ba;
      r_addr     <= w_addr;
      r_done     <= w_done;
      r_busy     <= w_busy;
    end
  end

  assign o_init_cmd  = r_cmd;
  assign o_init_ba   = r_ba;
  assign o_init_addr = r_addr;
  assign o_init_done = r_done;
  assign o_init_busy = r_busy;

endmodule
